// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Each digit slot is a blanking guard followed by a drive phase; loads commit at frame wrap.
module seg_scan_ctrl #(
  parameter int unsigned NDIG      = 4,
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [4*NDIG-1:0] data_in,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              load,
  output logic              busy,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame_tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(NDIG);

  localparam logic [CW-1:0] CntLast   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BlankLast = CW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
  localparam logic [DW-1:0] DigLast   = DW'(NDIG - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBlank = 2'd1;
  localparam logic [1:0] StDrive = 2'd2;
  // Slots start in DRIVE directly when there is no blanking guard.
  localparam logic [1:0] StSlot  = (BLANK_CYC == 0) ? StDrive : StBlank;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     digit_q, digit_d;
  logic [4*NDIG-1:0] active_q, active_d;
  logic [NDIG-1:0]   active_dp_q, active_dp_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [NDIG-1:0]   shadow_dp_q, shadow_dp_d;
  logic              busy_q, busy_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              ft_q, ft_d;
  logic              wrap;
  logic [3:0]        nib;
  logic              dp_sel;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign wrap = (state_q == StDrive) && (cnt_q == CntLast) && (digit_q == DigLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    case (state_q)
      StIdle: begin
        cnt_d   = '0;
        digit_d = '0;
        if (en) state_d = StSlot;
      end
      StBlank: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == BlankLast) state_d = StDrive;
      end
      StDrive: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          digit_d = (digit_q == DigLast) ? '0 : digit_q + DW'(1);
          state_d = StSlot;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
      digit_d = '0;
    end
  end

  always_comb begin
    active_d    = active_q;
    active_dp_d = active_dp_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    busy_d      = busy_q;
    if (state_q == StIdle && busy_q) begin
      active_d    = shadow_q;
      active_dp_d = shadow_dp_q;
      busy_d      = 1'b0;
    end
    if (load) begin
      shadow_d    = data_in;
      shadow_dp_d = dp_in;
      busy_d      = 1'b1;
    end
    // A load landing on the wrap cycle bypasses the shadow and commits immediately.
    if (wrap) begin
      if (load) begin
        active_d    = data_in;
        active_dp_d = dp_in;
        busy_d      = 1'b0;
      end else if (busy_q) begin
        active_d    = shadow_q;
        active_dp_d = shadow_dp_q;
        busy_d      = 1'b0;
      end
    end
  end

  // Outputs are decoded from next state so the registered pins line up with state_q.
  always_comb begin
    nib    = active_d[3:0];
    dp_sel = active_dp_d[0];
    an_d   = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (digit_d == DW'(i)) begin
        nib    = active_d[4*i +: 4];
        dp_sel = active_dp_d[i];
        an_d[i] = (state_d != StDrive);
      end
    end
    seg_d = (state_d == StDrive) ? hex7(nib) : 7'h7F;
    dp_d  = (state_d == StDrive) ? ~dp_sel : 1'b1;
    ft_d  = (state_d == StDrive) && (cnt_d == CntLast) && (digit_d == DigLast);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      digit_q     <= '0;
      active_q    <= '0;
      active_dp_q <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      busy_q      <= 1'b0;
      an_q        <= '1;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      ft_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      active_q    <= active_d;
      active_dp_q <= active_dp_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      busy_q      <= busy_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      ft_q        <= ft_d;
    end
  end

  assign busy       = busy_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  seg_scan_ctrl #(
    .NDIG      (4),
    .TICK_DIV  (10),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .load       (load),
    .busy       (busy),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned stamp;
    int          tid;
    int          k;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;
    logic        ft;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          tid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  // Monitor: compare every expectation due this cycle; anything older was missed.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].stamp <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.stamp < cyc) begin
        errors++;
        $display("FAIL stale_t%0d stamp=%0d cyc=%0d", e.tid, e.stamp, cyc);
      end else if (an !== e.an || seg !== e.seg || dp !== e.dp || busy !== e.busy ||
                   frame_tick !== e.ft) begin
        errors++;
        $display("FAIL scan_t%0d k=%0d cyc=%0d got an=%h seg=%h dp=%b busy=%b ft=%b want an=%h seg=%h dp=%b busy=%b ft=%b",
                 e.tid, e.k, cyc, an, seg, dp, busy, frame_tick,
                 e.an, e.seg, e.dp, e.busy, e.ft);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dark(input logic b);
    exp_t e;
    e.stamp = cyc + 1; e.tid = tid; e.k = -1;
    e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.busy = b; e.ft = 1'b0;
    q.push_back(e);
  endtask

  // k counts cycles from the first BLANK cycle after enable: 10-cycle slots, 2 blank + 8 drive.
  task automatic push_scan(input int k, input logic [15:0] v, input logic [3:0] dv,
                           input logic b);
    exp_t e;
    int   slot, ph;
    logic [3:0] nib;
    slot = (k / 10) % 4;
    ph   = k % 10;
    nib  = 4'((v >> (slot * 4)) & 16'hF);
    e.stamp = cyc + 1; e.tid = tid; e.k = k; e.busy = b;
    e.ft = ((k % 40) == 39);
    if (ph < 2) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
    end else begin
      e.an  = ~(4'b0001 << slot);
      e.seg = hex7(nib);
      e.dp  = ~dv[slot];
    end
    q.push_back(e);
  endtask

  task automatic scan(input int k0, input int n, input logic [15:0] v,
                      input logic [3:0] dv, input logic b);
    for (int i = 0; i < n; i++) begin
      push_scan(k0 + i, v, dv, b);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset held with en/load active stays dark and idle.
    tid = 1;
    reset = 1'b0; en = 1'b1; load = 1'b1; data_in = 16'h1234; dp_in = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      push_dark(1'b0);
      tick();
    end

    // 2: load in IDLE, then enable and scan one full frame of 1234.
    tid = 2;
    reset = 1'b1; en = 1'b0; load = 1'b1; data_in = 16'h1234; dp_in = 4'b0001;
    push_dark(1'b1);
    tick();
    load = 1'b0; en = 1'b1;
    scan(0, 40, 16'h1234, 4'b0001, 1'b0);

    // 3: mid-frame load stays pending until the wrap.
    tid = 3;
    scan(40, 15, 16'h1234, 4'b0001, 1'b0);
    load = 1'b1; data_in = 16'hABCD; dp_in = 4'b0000;
    push_scan(55, 16'h1234, 4'b0001, 1'b1);
    tick();
    load = 1'b0; data_in = 16'h5555; dp_in = 4'b1111;
    scan(56, 24, 16'h1234, 4'b0001, 1'b1);
    scan(80, 40, 16'hABCD, 4'b0000, 1'b0);

    // 4: load on the frame_tick cycle commits straight to the display.
    tid = 4;
    scan(120, 40, 16'hABCD, 4'b0000, 1'b0);
    load = 1'b1; data_in = 16'h00F0; dp_in = 4'b0000;
    push_scan(160, 16'h00F0, 4'b0000, 1'b0);
    tick();
    load = 1'b0; data_in = 16'h7777; dp_in = 4'b1010;
    scan(161, 39, 16'h00F0, 4'b0000, 1'b0);

    // 5: drop en during digit2 drive, then restart from digit0 blank.
    tid = 5;
    scan(200, 25, 16'h00F0, 4'b0000, 1'b0);
    en = 1'b0;
    push_dark(1'b0);
    tick();
    push_dark(1'b0);
    tick();
    en = 1'b1;
    scan(0, 12, 16'h00F0, 4'b0000, 1'b0);

    // 6: reset with a pending load clears both buffers.
    tid = 6;
    load = 1'b1; data_in = 16'h8888; dp_in = 4'b1111;
    push_scan(12, 16'h00F0, 4'b0000, 1'b1);
    tick();
    load = 1'b0;
    scan(13, 3, 16'h00F0, 4'b0000, 1'b1);
    reset = 1'b0;
    push_dark(1'b0);
    tick();
    push_dark(1'b0);
    tick();
    reset = 1'b1;
    scan(0, 40, 16'h0000, 4'b0000, 1'b0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
